// File: rtl/bridge_bus_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing the serial-bridge register bus.
// Optional WAIT timeout is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bridge_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r0_rw,
    output logic                  r0_resp_valid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r1_rw,
    output logic                  r1_resp_valid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,

    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic                  bus_rw_o,
    output logic                  bus_valid_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_resp_valid_i,
    output logic                  owner_o
);

    // state | meaning
    // IDLE  | no transaction; grant offered to requesters
    // ISSUE | bus strobe cycle; responses ignored
    // WAIT  | awaiting chain response (or timeout)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  run_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  bus_rw_q, bus_rw_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  resp0_q, resp0_d, resp1_q, resp1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  grant, accept;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err0_q, err0_d, err1_q, err1_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT);
`endif

    // Tie goes to the requester that did not win last; a lone requester always wins.
    assign grant  = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
    // run_q keeps ready low until the first clock after reset release.
    assign accept = run_q && (state_q == ST_IDLE) && (r0_valid || r1_valid);

    assign r0_ready = accept && !grant;
    assign r1_ready = accept && grant;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_rw_d     = bus_rw_q;
        bus_valid_d  = 1'b0;
        resp0_d      = 1'b0;
        resp1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bus_addr_d   = grant ? r1_addr  : r0_addr;
                    bus_wdata_d  = grant ? r1_wdata : r0_wdata;
                    bus_rw_d     = grant ? r1_rw    : r0_rw;
                    bus_valid_d  = 1'b1;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
            end
            ST_WAIT: begin
                if (bus_resp_valid_i) begin
                    if (owner_q) begin
                        resp1_d  = 1'b1;
                        rdata1_d = bus_rdata_i;
`ifdef BUS_ARB_TIMEOUT_EN
                        err1_d   = 1'b0;
`endif
                    end else begin
                        resp0_d  = 1'b1;
                        rdata0_d = bus_rdata_i;
`ifdef BUS_ARB_TIMEOUT_EN
                        err0_d   = 1'b0;
`endif
                    end
                    state_d = ST_IDLE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    if (owner_q) begin
                        resp1_d  = 1'b1;
                        rdata1_d = '0;
                        err1_d   = 1'b1;
                    end else begin
                        resp0_d  = 1'b1;
                        rdata0_d = '0;
                        err0_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            run_q        <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_rw_q     <= 1'b0;
            bus_valid_q  <= 1'b0;
            resp0_q      <= 1'b0;
            resp1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= 16'd0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            run_q        <= 1'b1;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_rw_q     <= bus_rw_d;
            bus_valid_q  <= bus_valid_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
`endif
        end
    end

    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_rw_o      = bus_rw_q;
    assign bus_valid_o   = bus_valid_q;
    assign owner_o       = owner_q;
    assign r0_resp_valid = resp0_q;
    assign r1_resp_valid = resp1_q;
    assign r0_rdata      = rdata0_q;
    assign r1_rdata      = rdata1_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign r0_err        = err0_q;
    assign r1_err        = err1_q;
`else
    assign r0_err        = 1'b0;
    assign r1_err        = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// Directed bench for bridge_bus_arbiter; timeout vectors run when BUS_ARB_TIMEOUT_EN is defined.
module tb_bridge_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_rw, r0_resp_valid, r0_err;
    logic [15:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_rw, r1_resp_valid, r1_err;
    logic [15:0] r1_addr, r1_wdata, r1_rdata;
    logic [15:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        bus_rw_o, bus_valid_o, bus_resp_valid_i, owner_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bridge_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rw(r0_rw), .r0_resp_valid(r0_resp_valid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rw(r1_rw), .r1_resp_valid(r1_resp_valid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rw_o(bus_rw_o),
        .bus_valid_o(bus_valid_o), .bus_rdata_i(bus_rdata_i),
        .bus_resp_valid_i(bus_resp_valid_i), .owner_o(owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {r0_ready, r1_ready, r0_resp_valid, r1_resp_valid,
                                 r0_err, r1_err, bus_rw_o, bus_valid_o, owner_o}, 32'd0);
        check_val({tag, "_rdata"}, {r0_rdata, r1_rdata}, 32'd0);
        check_val({tag, "_bus"}, {bus_addr_o, bus_wdata_o}, 32'd0);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 8 && !(r0_ready || r1_ready); n++) tick();
        check_val("ready_seen", {31'd0, r0_ready || r1_ready}, 32'd1);
    endtask

    // Presents a request, checks it is the one granted, and returns just after the accept edge.
    task automatic issue(input int req, input logic [15:0] a, input logic [15:0] wd, input logic rw);
        if (req == 0) begin
            r0_valid = 1'b1; r0_addr = a; r0_wdata = wd; r0_rw = rw;
        end else begin
            r1_valid = 1'b1; r1_addr = a; r1_wdata = wd; r1_rw = rw;
        end
        #1;
        wait_ready();
        check_val("grant_idx", {31'd0, r1_ready}, req);
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check_val("accept_strobe", {31'd0, bus_valid_o}, 32'd1);
        check_val("accept_owner", {31'd0, owner_o}, req);
    endtask

    task automatic respond(input logic [15:0] d);
        bus_resp_valid_i = 1'b1;
        bus_rdata_i      = d;
        tick();
        bus_resp_valid_i = 1'b0;
    endtask

    initial begin
        int prev;
        int acc;
        int g;
        rst_n = 1'b1;
        r0_valid = 0; r0_addr = 0; r0_wdata = 0; r0_rw = 0;
        r1_valid = 0; r1_addr = 0; r1_wdata = 0; r1_rw = 0;
        bus_rdata_i = 0; bus_resp_valid_i = 0;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Both requesters held: alternate 0,1,0,1, one accept every 3 cycles.
        r0_valid = 1'b1; r0_addr = 16'h00A0; r0_rw = 1'b0;
        r1_valid = 1'b1; r1_addr = 16'h00B1; r1_rw = 1'b0;
        #1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            wait_ready();
            check_val("rr_grant", {31'd0, r1_ready}, g);
            check_val("rr_excl", {31'd0, r0_ready & r1_ready}, 32'd0);
            tick();
            acc = cyc;
            check_val("rr_owner", {31'd0, owner_o}, g);
            check_val("rr_addr", bus_addr_o, (g == 1) ? 32'h00B1 : 32'h00A0);
            if (i > 0) check_val("rr_period", acc - prev, 32'd3);
            prev = acc;
            tick();
            respond(16'h1000 + 16'(i));
            check_val("rr_resp", {30'd0, r1_resp_valid, r0_resp_valid}, (g == 1) ? 32'd2 : 32'd1);
            check_val("rr_rdata", (g == 1) ? r1_rdata : r0_rdata, 32'h1000 + i);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();

        // Single read from requester 0, response 3 cycles after the strobe.
        issue(0, 16'h0012, 16'h0000, 1'b0);
        check_val("rd_addr", bus_addr_o, 32'h0012);
        check_val("rd_rw", {31'd0, bus_rw_o}, 32'd0);
        check_val("rd_ready_low", {31'd0, r0_ready}, 32'd0);
        tick();
        check_val("rd_strobe_one", {31'd0, bus_valid_o}, 32'd0);
        check_val("rd_addr_hold", bus_addr_o, 32'h0012);
        tick();
        respond(16'hBEEF);
        check_val("rd_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd1);
        check_val("rd_rdata", r0_rdata, 32'hBEEF);
        check_val("rd_err", {31'd0, r0_err}, 32'd0);
        tick();
        check_val("rd_resp_pulse", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        check_val("rd_rdata_hold", r0_rdata, 32'hBEEF);

        // Write from requester 1, with a stale response during ISSUE.
        issue(1, 16'h0400, 16'h1234, 1'b1);
        check_val("wr_wdata", bus_wdata_o, 32'h1234);
        check_val("wr_rw", {31'd0, bus_rw_o}, 32'd1);
        check_val("wr_addr", bus_addr_o, 32'h0400);
        respond(16'hDEAD);
        check_val("issue_stale", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        tick();
        tick();
        check_val("wait_quiet", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        respond(16'h5A5A);
        check_val("wr_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd2);
        check_val("wr_rdata", r1_rdata, 32'h5A5A);
        check_val("r0_rdata_kept", r0_rdata, 32'hBEEF);
        tick();

        // Stale response in IDLE, then a normal transaction.
        respond(16'h7777);
        check_val("idle_stale", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        check_val("idle_stale_data", r1_rdata, 32'h5A5A);
        issue(0, 16'h0055, 16'h0000, 1'b0);
        tick();
        respond(16'h0A0A);
        check_val("post_stale_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd1);
        check_val("post_stale_rdata", r0_rdata, 32'h0A0A);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // TIMEOUT=4: error pulse on the 4th WAIT cycle without a response.
        issue(0, 16'h0077, 16'h0000, 1'b0);
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val("to_quiet", {31'd0, r0_resp_valid}, 32'd0);
        end
        tick();
        check_val("to_resp", {31'd0, r0_resp_valid}, 32'd1);
        check_val("to_err", {31'd0, r0_err}, 32'd1);
        check_val("to_rdata", r0_rdata, 32'd0);
        tick();
        respond(16'h2222);
        check_val("to_late_drop", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        check_val("to_err_hold", {31'd0, r0_err}, 32'd1);
        check_val("to_rdata_hold", r0_rdata, 32'd0);
        issue(0, 16'h0078, 16'h0000, 1'b0);
        tick(); tick(); tick(); tick();
        respond(16'hCAFE);
        check_val("to_tie_resp", {31'd0, r0_resp_valid}, 32'd1);
        check_val("to_tie_err", {31'd0, r0_err}, 32'd0);
        check_val("to_tie_rdata", r0_rdata, 32'hCAFE);
        tick();
`else
        // Without the timeout, WAIT holds as long as the chain is silent.
        issue(0, 16'h0066, 16'h0000, 1'b0);
        for (int j = 0; j < 8; j++) begin
            tick();
            check_val("nt_quiet", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        end
        respond(16'h1111);
        check_val("nt_resp", {31'd0, r0_resp_valid}, 32'd1);
        check_val("nt_err", {31'd0, r0_err}, 32'd0);
        check_val("nt_rdata", r0_rdata, 32'h1111);
        tick();
`endif

        // Reset mid-WAIT: outputs clear at once, late response ignored, next request normal.
        issue(1, 16'h0300, 16'h0000, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        respond(16'h9999);
        check_val("midrst_stale", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
        check_val("midrst_rdata", r1_rdata, 32'd0);
        issue(0, 16'h0123, 16'h0000, 1'b0);
        check_val("midrst_addr", bus_addr_o, 32'h0123);
        tick();
        respond(16'h4321);
        check_val("midrst_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd1);
        check_val("midrst_rdata0", r0_rdata, 32'h4321);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_bus_arbiter.md
# bridge_bus_arbiter

Two-requester arbiter and sequencer for the shared register bus that the serial bridge drives. It accepts decoded transactions (address, write data, read/write) from the host bridge receiver and from a second on-chip requester, grants one at a time round-robin, and issues a single-cycle bus strobe. It then waits for the core chain's response and returns read data, or an error flag, to the requester that owns the transaction.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 16, bus data width
- TIMEOUT, 255, maximum WAIT cycles before an error response (used only with timeout compiled in); legal range 1..65535

Ports (N = 0, 1; requester 0 is the host bridge):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rN_valid  in  1  request pending; requester holds it and its fields stable until accepted
- rN_ready  out  1  acceptance; transfer occurs on an edge where rN_valid && rN_ready
- rN_addr  in  ADDR_WIDTH  request address
- rN_wdata  in  DATA_WIDTH  write data
- rN_rw  in  1  1 = write, 0 = read
- rN_resp_valid  out  1  one-cycle response pulse
- rN_rdata  out  DATA_WIDTH  response data, valid with rN_resp_valid
- rN_err  out  1  timeout flag, valid with rN_resp_valid
- bus_addr_o  out  ADDR_WIDTH  address to core chain
- bus_wdata_o  out  DATA_WIDTH  write data to core chain
- bus_rw_o  out  1  read/write to core chain
- bus_valid_o  out  1  one-cycle transaction strobe
- bus_rdata_i  in  DATA_WIDTH  returned data
- bus_resp_valid_i  in  1  response strobe from chain end
- owner_o  out  1  index of the current or last granted requester

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant is combinational from the two valids and the last_grant register.
  - A single requester always wins. On a tie, the requester other than last_grant wins.
  - rN_ready = (state == IDLE) && grant == N. It is never high outside IDLE.
  - On accept: latch addr, wdata and rw into the bus_* outputs; set owner_o and last_grant to N; go to ISSUE.
- ISSUE: bus_valid_o = 1 for exactly this cycle. bus_resp_valid_i is ignored. Go to WAIT.
- WAIT:
  - On bus_resp_valid_i: capture bus_rdata_i into rOWNER_rdata, pulse rOWNER_resp_valid with err = 0, go to IDLE.
  - Responses are returned for writes as well as reads; write rdata is whatever the chain returns.
- bus_resp_valid_i in IDLE or ISSUE (a stale or late response) is dropped with no output effect.
- Each rN_rdata and rN_err holds its last value until that requester's next response.
- The non-owner's resp_valid never pulses.
- Reset values: every output 0. State is IDLE, last_grant = 1 (so requester 0 wins the first tie), timeout counter 0.
- Reset mid-transaction:
  - The transaction is abandoned with no response.
  - Any bus response arriving after reset release is dropped as stale.

## Timing
- Accept at edge k. bus_valid_o is high from k to k+1. The state is WAIT from edge k+1.
- Response sampled at edge m (m ≥ k+2): rN_resp_valid is high from m to m+1. The state is IDLE from edge m, so a new accept is possible at edge m+1.
- Minimum transaction period: 3 cycles.
- Bus outputs are registered and hold their values after the strobe until the next accept.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments on each WAIT cycle without a response.
  - When the count reaches TIMEOUT, pulse rOWNER_resp_valid with err = 1 and rdata = 0, then go to IDLE.
  - If a response and the timeout occur on the same cycle, the response wins with err = 0.
  - A response arriving after a timeout is dropped as stale.
- BUS_ARB_TIMEOUT_EN undefined:
  - WAIT lasts indefinitely and the counter is not built.
  - rN_err is tied to 0.
  - TIMEOUT is ignored.

## Test plan
- Single read from requester 0: addr 0x0012, chain returns 0xBEEF 3 cycles after the strobe. Expect r0_ready pulse, bus_valid_o one cycle with addr 0x0012 and rw 0, then r0_resp_valid with rdata 0xBEEF and err 0. r1_resp_valid stays low.
- Simultaneous requests held continuously, response after 1 cycle each: grants alternate 0,1,0,1, starting with 0 after reset. owner_o tracks each grant. Each accept is 3 cycles apart.
- Write from requester 1: addr 0x0400, wdata 0x1234, rw 1. Expect bus_wdata_o = 0x1234, bus_rw_o = 1, and r1_resp_valid after the response.
- Stale responses: bus_resp_valid_i pulsed while in IDLE and during ISSUE produces no resp_valid and no state change.
- Timeout with BUS_ARB_TIMEOUT_EN and TIMEOUT = 4, no response: r0_resp_valid pulses with err 1 and rdata 0. A response arriving 2 cycles later is dropped. Repeat with the response on exactly the timeout cycle: expect err 0.
- Reset mid-WAIT: drop rst_n. All outputs read 0 immediately. After release, a response from the chain is ignored and the next request completes normally.
